// File: rtl/mcore_pkg.sv
// Shared definitions for the mcore register block: region bases, UTIL offsets, fill FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mcore_defs;

    // Region base byte addresses; regions are 4 KB and decoded on address bits [31:12]
    localparam logic [31:0] M_REGS_ADDR     = 32'h0000_0000;
    localparam logic [31:0] M_CEL_VARS_ADDR = 32'h0000_1000;
    localparam logic [31:0] M_UTIL_ADDR     = 32'h0000_2000;

    // Depth of the REGS and CEL_VARS arrays; higher word indices alias modulo this
    localparam int MEM_DEPTH = 64;

    // UTIL region register byte offsets
    localparam logic [11:0] UTIL_DST_OFF  = 12'h000;
    localparam logic [11:0] UTIL_CTRL_OFF = 12'h004;
    localparam logic [11:0] UTIL_LEN_OFF  = 12'h008;
    localparam logic [11:0] UTIL_PAT_OFF  = 12'h00C;

    // Fill engine states; the encoding is visible on the debug word
    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_ADDR = 2'd1,
        FILL_RESP = 2'd2,
        FILL_DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/mcore_util_fill.sv
// Fill engine: writes LEN copies of PAT over AXI-Lite starting at DST, one outstanding beat at a time.
// Latency: two cycles per beat with readies high and an immediate b_valid, plus one DONE cycle.
// Backpressure: aw/w valids hold until their own ready; the next beat waits for b_valid.
module mcore_util_fill
    import mcore_defs::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [AXI_ADDR_WIDTH-1:0]   dst,
    input  logic [31:0]                 len,
    input  logic [AXI_DATA_WIDTH-1:0]   pat,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    output logic                        aw_valid,
    input  logic                        aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]   w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    output logic                        w_valid,
    input  logic                        w_ready,
    output logic                        b_ready,
    input  logic                        b_valid,
    output logic                        done,
    output logic                        busy,
    output fill_state_t                 state,
    output logic [31:0]                 cnt
);

    fill_state_t                 state_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   cur_dst;
    logic [31:0]                 cur_len;
    logic [AXI_DATA_WIDTH-1:0]   cur_pat;
    logic                        aw_sent;
    logic                        w_sent;
    logic                        aw_hs;
    logic                        w_hs;

    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; starts are only honoured from IDLE so a busy engine ignores them
    always_comb begin
        state_nxt = state;
        case (state)
            FILL_IDLE: begin
                if (start) begin
                    state_nxt = (len == 32'd0) ? FILL_DONE : FILL_ADDR;
                end
            end
            FILL_ADDR: begin
                if ((aw_sent || aw_hs) && (w_sent || w_hs)) begin
                    state_nxt = FILL_RESP;
                end
            end
            FILL_RESP: begin
                if (b_valid) begin
                    state_nxt = (cnt + 32'd1 == cur_len) ? FILL_DONE : FILL_ADDR;
                end
            end
            FILL_DONE: begin
                state_nxt = FILL_IDLE;
            end
            default: begin
                state_nxt = FILL_IDLE;
            end
        endcase
    end

    // Output decode; each valid drops on its own once its handshake has happened
    always_comb begin
        aw_valid = (state == FILL_ADDR) && !aw_sent;
        w_valid  = (state == FILL_ADDR) && !w_sent;
        b_ready  = (state == FILL_RESP);
        busy     = (state != FILL_IDLE);
    end

    // Working copies of DST/LEN/PAT, beat counter, per-channel handshake flags and done
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_dst <= '0;
            cur_len <= '0;
            cur_pat <= '0;
            cnt     <= '0;
            aw_sent <= 1'b0;
            w_sent  <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (state == FILL_IDLE && start) begin
                cur_dst <= dst;
                cur_len <= len;
                cur_pat <= pat;
                cnt     <= '0;
                done    <= 1'b0;
            end
            if (state == FILL_DONE) begin
                done <= 1'b1;
            end
            if (state == FILL_ADDR) begin
                if (aw_hs) aw_sent <= 1'b1;
                if (w_hs)  w_sent  <= 1'b1;
            end else begin
                aw_sent <= 1'b0;
                w_sent  <= 1'b0;
            end
            if (state == FILL_RESP && b_valid) begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    // Beat address wraps naturally at the address width
    assign aw_addr = cur_dst + (AXI_ADDR_WIDTH'(cnt) << 2);
    assign w_data  = cur_pat;
    assign w_strb  = '1;

endmodule

// File: rtl/mcore_top.sv
// Register block with REGS/CEL_VARS storage and a UTIL fill engine mastering AXI-Lite writes.
// Latency: register writes take effect at the clock edge; reads are combinational.
// Backpressure: register port never stalls; AXI side follows valid/ready. Optional MCORE_DEBUG_EN exposes FSM status on debug.
module mcore_top
    import mcore_defs::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        mr_clka,
    input  logic                        mr_rsta,
    input  logic [ADDR_WIDTH-1:0]       mr_addra,
    input  logic [DATA_WIDTH-1:0]       mr_dina,
    output logic [DATA_WIDTH-1:0]       mr_douta,
    input  logic                        mr_ena,
    input  logic [DATA_WIDTH/8-1:0]     mr_wea,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_aw_addr,
    output logic [2:0]                  m_axi_aw_prot,
    output logic                        m_axi_aw_valid,
    input  logic                        m_axi_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_w_strb,
    output logic                        m_axi_w_valid,
    input  logic                        m_axi_w_ready,
    output logic                        m_axi_b_ready,
    input  logic [1:0]                  m_axi_b_resp,
    input  logic                        m_axi_b_valid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_ar_addr,
    output logic [2:0]                  m_axi_ar_prot,
    output logic                        m_axi_ar_valid,
    input  logic                        m_axi_ar_ready,
    output logic                        m_axi_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_r_data,
    input  logic [1:0]                  m_axi_r_resp,
    input  logic                        m_axi_r_valid,
    output logic [31:0]                 debug
);

    localparam int NB = DATA_WIDTH / 8;

    logic                   rst;
    logic                   wr;
    logic                   sel_regs;
    logic                   sel_cel;
    logic                   sel_util;
    logic [5:0]             mem_idx;
    logic [9:0]             util_idx;
    logic [DATA_WIDTH-1:0]  wmask;
    logic                   fill_start;
    logic                   fill_done;
    logic                   fill_busy;
    fill_state_t            fill_state;
    logic [31:0]            fill_cnt;

    logic [DATA_WIDTH-1:0]  regs_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]  cel_mem  [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]  util_dst;
    logic [DATA_WIDTH-1:0]  util_len;
    logic [DATA_WIDTH-1:0]  util_pat;

    assign rst      = !aresetn || mr_rsta;
    assign wr       = mr_ena && (mr_wea != '0);
    assign sel_regs = (mr_addra[31:12] == M_REGS_ADDR[31:12]);
    assign sel_cel  = (mr_addra[31:12] == M_CEL_VARS_ADDR[31:12]);
    assign sel_util = (mr_addra[31:12] == M_UTIL_ADDR[31:12]);
    assign mem_idx  = mr_addra[7:2];
    assign util_idx = mr_addra[11:2];

    // Only byte 0 of CTRL carries the start bit
    assign fill_start = wr && sel_util && (util_idx == UTIL_CTRL_OFF[11:2])
                        && mr_wea[0] && mr_dina[0];

    // Expand byte enables into a bit mask for read-modify-write merges
    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++) begin
            wmask[b*8 +: 8] = {8{mr_wea[b]}};
        end
    end

    // REGS and CEL_VARS storage with per-byte writes
    always_ff @(posedge aclk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                regs_mem[i] <= '0;
                cel_mem[i]  <= '0;
            end
        end else if (wr) begin
            if (sel_regs) begin
                regs_mem[mem_idx] <= (regs_mem[mem_idx] & ~wmask) | (mr_dina & wmask);
            end
            if (sel_cel) begin
                cel_mem[mem_idx] <= (cel_mem[mem_idx] & ~wmask) | (mr_dina & wmask);
            end
        end
    end

    // UTIL parameter registers; writes land even mid-fill since the engine keeps its own copies
    always_ff @(posedge aclk) begin
        if (rst) begin
            util_dst <= '0;
            util_len <= '0;
            util_pat <= '0;
        end else if (wr && sel_util) begin
            if (util_idx == UTIL_DST_OFF[11:2]) util_dst <= (util_dst & ~wmask) | (mr_dina & wmask);
            if (util_idx == UTIL_LEN_OFF[11:2]) util_len <= (util_len & ~wmask) | (mr_dina & wmask);
            if (util_idx == UTIL_PAT_OFF[11:2]) util_pat <= (util_pat & ~wmask) | (mr_dina & wmask);
        end
    end

    // Combinational read mux; anything unmapped or any write cycle returns zero
    always_comb begin
        mr_douta = '0;
        if (mr_ena && mr_wea == '0) begin
            if (sel_regs) begin
                mr_douta = regs_mem[mem_idx];
            end else if (sel_cel) begin
                mr_douta = cel_mem[mem_idx];
            end else if (sel_util) begin
                case (util_idx)
                    UTIL_DST_OFF[11:2]:  mr_douta = util_dst;
                    UTIL_CTRL_OFF[11:2]: mr_douta[1:0] = {fill_busy, fill_done};
                    UTIL_LEN_OFF[11:2]:  mr_douta = util_len;
                    UTIL_PAT_OFF[11:2]:  mr_douta = util_pat;
                    default:             mr_douta = '0;
                endcase
            end
        end
    end

    mcore_util_fill #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_fill (
        .clk      (aclk),
        .rst      (rst),
        .start    (fill_start),
        .dst      (AXI_ADDR_WIDTH'(util_dst)),
        .len      (32'(util_len)),
        .pat      (AXI_DATA_WIDTH'(util_pat)),
        .aw_addr  (m_axi_aw_addr),
        .aw_valid (m_axi_aw_valid),
        .aw_ready (m_axi_aw_ready),
        .w_data   (m_axi_w_data),
        .w_strb   (m_axi_w_strb),
        .w_valid  (m_axi_w_valid),
        .w_ready  (m_axi_w_ready),
        .b_ready  (m_axi_b_ready),
        .b_valid  (m_axi_b_valid),
        .done     (fill_done),
        .busy     (fill_busy),
        .state    (fill_state),
        .cnt      (fill_cnt)
    );

    assign m_axi_aw_prot  = 3'b000;
    assign m_axi_ar_addr  = '0;
    assign m_axi_ar_prot  = 3'b000;
    assign m_axi_ar_valid = 1'b0;
    assign m_axi_r_ready  = 1'b1;

`ifdef MCORE_DEBUG_EN
    assign debug = {fill_cnt[15:0], 12'b0, fill_state, fill_busy, fill_done};
`else
    assign debug = 32'h0;
`endif

    // Inputs with no function here (unused read channel, b_resp, port clock) are sunk
    logic unused;
    assign unused = ^{mr_clka, mr_addra[1:0], m_axi_b_resp, m_axi_ar_ready,
                      m_axi_r_data, m_axi_r_resp, m_axi_r_valid, fill_cnt, fill_state};

endmodule

// File: tb/tb_mcore_top.sv
// Bench for mcore_top: directed register and fill vectors, expected results queued and checked by a monitor.
// Latency: monitor samples on the falling edge; every stimulus task spans exactly one clock.
// Backpressure: bench toggles aw_ready to exercise independent aw/w handshakes.
module tb_mcore_top;

    logic        aclk;
    logic        aresetn;
    logic        mr_clka;
    logic        mr_rsta;
    logic [31:0] mr_addra;
    logic [31:0] mr_dina;
    logic [31:0] mr_douta;
    logic        mr_ena;
    logic [3:0]  mr_wea;
    logic [31:0] m_axi_aw_addr;
    logic [2:0]  m_axi_aw_prot;
    logic        m_axi_aw_valid;
    logic        m_axi_aw_ready;
    logic [31:0] m_axi_w_data;
    logic [3:0]  m_axi_w_strb;
    logic        m_axi_w_valid;
    logic        m_axi_w_ready;
    logic        m_axi_b_ready;
    logic [1:0]  m_axi_b_resp;
    logic        m_axi_b_valid;
    logic [31:0] m_axi_ar_addr;
    logic [2:0]  m_axi_ar_prot;
    logic        m_axi_ar_valid;
    logic        m_axi_ar_ready;
    logic        m_axi_r_ready;
    logic [31:0] m_axi_r_data;
    logic [1:0]  m_axi_r_resp;
    logic        m_axi_r_valid;
    logic [31:0] debug;

    int checks = 0;
    int errors = 0;

    // Expected AXI beats, register reads and direct signal probes
    logic [34:0] aw_q [$];
    logic [35:0] w_q  [$];
    logic [31:0] rd_q [$];
    string       rd_nm [$];
    int          pr_id [$];
    logic [31:0] pr_exp [$];

    localparam logic [31:0] REGS = 32'h0000_0000;
    localparam logic [31:0] CEL  = 32'h0000_1000;
    localparam logic [31:0] DST  = 32'h0000_2000;
    localparam logic [31:0] CTRL = 32'h0000_2004;
    localparam logic [31:0] LEN  = 32'h0000_2008;
    localparam logic [31:0] PAT  = 32'h0000_200C;

    mcore_top dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .mr_clka        (mr_clka),
        .mr_rsta        (mr_rsta),
        .mr_addra       (mr_addra),
        .mr_dina        (mr_dina),
        .mr_douta       (mr_douta),
        .mr_ena         (mr_ena),
        .mr_wea         (mr_wea),
        .m_axi_aw_addr  (m_axi_aw_addr),
        .m_axi_aw_prot  (m_axi_aw_prot),
        .m_axi_aw_valid (m_axi_aw_valid),
        .m_axi_aw_ready (m_axi_aw_ready),
        .m_axi_w_data   (m_axi_w_data),
        .m_axi_w_strb   (m_axi_w_strb),
        .m_axi_w_valid  (m_axi_w_valid),
        .m_axi_w_ready  (m_axi_w_ready),
        .m_axi_b_ready  (m_axi_b_ready),
        .m_axi_b_resp   (m_axi_b_resp),
        .m_axi_b_valid  (m_axi_b_valid),
        .m_axi_ar_addr  (m_axi_ar_addr),
        .m_axi_ar_prot  (m_axi_ar_prot),
        .m_axi_ar_valid (m_axi_ar_valid),
        .m_axi_ar_ready (m_axi_ar_ready),
        .m_axi_r_ready  (m_axi_r_ready),
        .m_axi_r_data   (m_axi_r_data),
        .m_axi_r_resp   (m_axi_r_resp),
        .m_axi_r_valid  (m_axi_r_valid),
        .debug          (debug)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    assign mr_clka = aclk;

    function automatic logic [31:0] probe_val(input int id);
        case (id)
            0:       return {31'b0, m_axi_aw_valid};
            1:       return {31'b0, m_axi_w_valid};
            2:       return {31'b0, m_axi_b_ready};
            3:       return {31'b0, m_axi_ar_valid};
            4:       return {31'b0, m_axi_r_ready};
            5:       return debug;
            6:       return m_axi_ar_addr;
            7:       return mr_douta;
            8:       return aw_q.size();
            default: return w_q.size();
        endcase
    endfunction

    function automatic string probe_name(input int id);
        case (id)
            0:       return "aw_valid";
            1:       return "w_valid";
            2:       return "b_ready";
            3:       return "ar_valid";
            4:       return "r_ready";
            5:       return "debug";
            6:       return "ar_addr";
            7:       return "douta_idle";
            8:       return "aw_beats_missing";
            default: return "w_beats_missing";
        endcase
    endfunction

    // Monitor: pops and compares whenever the DUT presents a handshake, a read, or a probe is due
    always @(negedge aclk) begin : mon
        logic [34:0] ea;
        logic [35:0] ew;
        logic [31:0] er;
        logic [31:0] av;
        string       nm;
        int          id;
        if (m_axi_aw_valid === 1'b1 && m_axi_aw_ready === 1'b1) begin
            checks++;
            if (aw_q.size() == 0) begin
                errors++;
                $display("FAIL aw_beat unexpected addr=%h", m_axi_aw_addr);
            end else begin
                ea = aw_q.pop_front();
                if ({m_axi_aw_prot, m_axi_aw_addr} !== ea) begin
                    errors++;
                    $display("FAIL aw_beat got prot/addr=%h want %h", {m_axi_aw_prot, m_axi_aw_addr}, ea);
                end
            end
        end
        if (m_axi_w_valid === 1'b1 && m_axi_w_ready === 1'b1) begin
            checks++;
            if (w_q.size() == 0) begin
                errors++;
                $display("FAIL w_beat unexpected data=%h", m_axi_w_data);
            end else begin
                ew = w_q.pop_front();
                if ({m_axi_w_strb, m_axi_w_data} !== ew) begin
                    errors++;
                    $display("FAIL w_beat got strb/data=%h want %h", {m_axi_w_strb, m_axi_w_data}, ew);
                end
            end
        end
        if (mr_ena && mr_wea == 4'b0 && rd_q.size() > 0) begin
            er = rd_q.pop_front();
            nm = rd_nm.pop_front();
            checks++;
            if (mr_douta !== er) begin
                errors++;
                $display("FAIL %s got %h want %h", nm, mr_douta, er);
            end
        end
        while (pr_id.size() > 0) begin
            id = pr_id.pop_front();
            er = pr_exp.pop_front();
            av = probe_val(id);
            checks++;
            if (av !== er) begin
                errors++;
                $display("FAIL %s got %h want %h", probe_name(id), av, er);
            end
        end
    end

    // Every stimulus task starts just after a rising edge and ends just after the next one
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mr_addra = a;
        mr_dina  = d;
        mr_wea   = be;
        mr_ena   = 1'b1;
        idle(1);
        mr_ena   = 1'b0;
        mr_wea   = 4'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        rd_q.push_back(e);
        rd_nm.push_back(n);
        mr_addra = a;
        mr_wea   = 4'b0;
        mr_ena   = 1'b1;
        idle(1);
        mr_ena   = 1'b0;
    endtask

    task automatic probe(input int id, input logic [31:0] e);
        pr_id.push_back(id);
        pr_exp.push_back(e);
    endtask

    task automatic expect_beats(input logic [31:0] dst, input int len, input logic [31:0] pat);
        logic [31:0] a;
        for (int i = 0; i < len; i++) begin
            a = dst + 32'(4 * i);
            aw_q.push_back({3'b000, a});
            w_q.push_back({4'hF, pat});
        end
    endtask

    // Polls STAT.done with a cycle budget; an expired budget shows up in the following STAT check
    task automatic wait_done();
        mr_addra = CTRL;
        mr_wea   = 4'b0;
        mr_ena   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (mr_douta[0] === 1'b1) break;
        end
        @(posedge aclk);
        #1;
        mr_ena = 1'b0;
    endtask

    initial begin
        aresetn        = 1'b0;
        mr_rsta        = 1'b0;
        mr_addra       = '0;
        mr_dina        = '0;
        mr_ena         = 1'b0;
        mr_wea         = 4'b0;
        m_axi_aw_ready = 1'b1;
        m_axi_w_ready  = 1'b1;
        m_axi_b_valid  = 1'b1;
        m_axi_b_resp   = 2'b10;
        m_axi_ar_ready = 1'b1;
        m_axi_r_data   = 32'hDEAD_0001;
        m_axi_r_resp   = 2'b00;
        m_axi_r_valid  = 1'b1;
        idle(3);
        aresetn = 1'b1;

        // Reset state
        probe(0, 0); probe(1, 0); probe(2, 0); probe(3, 0);
        probe(4, 1); probe(5, 0); probe(6, 0);
        idle(1);
        rd(CTRL, 32'h0, "reset_stat");
        rd(REGS, 32'h0, "reset_regs0");
        rd(CEL,  32'h0, "reset_cel0");

        // CEL_VARS write/read at several offsets
        wr(CEL + 32'h00, 32'h1234_5678, 4'hF);
        wr(CEL + 32'h40, 32'hCAFE_CAFE, 4'hF);
        wr(CEL + 32'h80, 32'hDEAD_DEAD, 4'hF);
        wr(CEL + 32'hC0, 32'hBEEF_BEEF, 4'hF);
        rd(CEL + 32'h00, 32'h1234_5678, "cel_00");
        rd(CEL + 32'h40, 32'hCAFE_CAFE, "cel_40");
        rd(CEL + 32'h80, 32'hDEAD_DEAD, "cel_80");
        rd(CEL + 32'hC0, 32'hBEEF_BEEF, "cel_c0");

        // Byte enables, aliasing, unmapped region, idle read port
        wr(REGS + 32'h10, 32'hFFFF_FFFF, 4'hF);
        wr(REGS + 32'h10, 32'h0000_0000, 4'b0001);
        rd(REGS + 32'h10, 32'hFFFF_FF00, "byte_enable");
        wr(REGS + 32'h104, 32'hA5A5_A5A5, 4'hF);
        rd(REGS + 32'h04, 32'hA5A5_A5A5, "regs_alias");
        wr(32'h0000_3000, 32'h5555_5555, 4'hF);
        rd(32'h0000_3000, 32'h0, "unmapped");
        mr_addra = REGS + 32'h10;
        probe(7, 32'h0);
        idle(1);

        // Fill 1: eight beats of 0xcafe0000
        wr(DST, 32'h7000_0000, 4'hF);
        wr(LEN, 32'd8, 4'hF);
        wr(PAT, 32'hCAFE_0000, 4'hF);
        expect_beats(32'h7000_0000, 8, 32'hCAFE_0000);
        wr(CTRL, 32'h1, 4'hF);
        wait_done();
        rd(CTRL, 32'h1, "fill1_stat");
        rd(DST, 32'h7000_0000, "dst_readback");
        probe(8, 0); probe(9, 0);
        idle(1);

        // Fill 2: done clears on start; a busy start and a busy PAT write leave the fill alone
        wr(PAT, 32'hBEEF_0000, 4'hF);
        expect_beats(32'h7000_0000, 8, 32'hBEEF_0000);
        wr(CTRL, 32'h1, 4'hF);
        rd(CTRL, 32'h2, "fill2_stat_after_start");
        wr(PAT, 32'h1111_1111, 4'hF);
        wr(CTRL, 32'h1, 4'hF);
        wait_done();
        rd(CTRL, 32'h1, "fill2_stat");
        rd(PAT, 32'h1111_1111, "pat_busy_write");
        probe(8, 0); probe(9, 0);
        idle(1);

        // Fill 3: aw_ready held low three cycles, address wraps past the top
        m_axi_aw_ready = 1'b0;
        wr(DST, 32'hFFFF_FFFC, 4'hF);
        wr(LEN, 32'd2, 4'hF);
        wr(PAT, 32'h0BAD_F00D, 4'hF);
        expect_beats(32'hFFFF_FFFC, 2, 32'h0BAD_F00D);
        wr(CTRL, 32'h1, 4'hF);
        probe(0, 1); probe(1, 1);
        idle(1);
        probe(0, 1); probe(1, 0);
        idle(1);
        probe(0, 1); probe(1, 0);
        idle(1);
        m_axi_aw_ready = 1'b1;
        wait_done();
        rd(CTRL, 32'h1, "fill3_stat");
        probe(8, 0); probe(9, 0);
        idle(1);

        // Fill 4: reset mid-fill aborts with no further handshakes
        wr(DST, 32'h0000_0100, 4'hF);
        wr(LEN, 32'd8, 4'hF);
        wr(PAT, 32'h5A5A_5A5A, 4'hF);
        expect_beats(32'h0000_0100, 8, 32'h5A5A_5A5A);
        wr(CTRL, 32'h1, 4'hF);
        idle(2);
        probe(0, 1);
        idle(2);
        aresetn = 1'b0;
        idle(1);
        aw_q.delete();
        w_q.delete();
        aresetn = 1'b1;
        probe(0, 0); probe(1, 0); probe(2, 0);
        idle(1);
        rd(CTRL, 32'h0, "abort_stat");
        rd(REGS + 32'h10, 32'h0, "abort_regs");
        rd(CEL + 32'h40, 32'h0, "abort_cel");
        rd(DST, 32'h0, "abort_dst");
        idle(20);

        // Port reset clears storage as well
        wr(REGS, 32'h0000_0001, 4'hF);
        mr_rsta = 1'b1;
        idle(1);
        mr_rsta = 1'b0;
        rd(REGS, 32'h0, "port_reset");

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/mcore_top.md
MCORE_TOP -- requirements
Module: mcore_top

Interface
REQ-001 Parameters: DATA_WIDTH=32 (register-port data width); ADDR_WIDTH=32 (register-port address width); AXI_ADDR_WIDTH=32 (master address width); AXI_DATA_WIDTH=32 (master data width).
REQ-002 Ports, one per line (name, direction, width, meaning):
- aclk  in  1  sole clock.
- aresetn  in  1  reset; one clock; reset is synchronous and active-low.
- mr_clka  in  1  register-port clock; tied to aclk; no logic is clocked by it.
- mr_rsta  in  1  active-high synchronous port reset; ORed with !aresetn.
- mr_addra  in  ADDR_WIDTH  byte address.
- mr_dina  in  DATA_WIDTH  write data.
- mr_douta  out  DATA_WIDTH  read data.
- mr_ena  in  1  access enable.
- mr_wea  in  DATA_WIDTH/8  byte write enables.
- m_axi_aw_addr/aw_prot(3)/aw_valid  out  AXI-Lite write address.
- m_axi_aw_ready  in  1.
- m_axi_w_data/w_strb/w_valid  out  AXI-Lite write data.
- m_axi_w_ready  in  1.
- m_axi_b_ready  out  1.
- m_axi_b_resp(2)/b_valid  in  write response.
- m_axi_ar_addr/ar_prot/ar_valid  out  read address.
- m_axi_ar_ready  in  1.
- m_axi_r_ready  out  1.
- m_axi_r_data/r_resp/r_valid  in  read data.
- debug  out  32  status word.

Function
REQ-003 Address map (byte addresses): M_REGS_ADDR=0x0000_0000, M_CEL_VARS_ADDR=0x0000_1000, M_UTIL_ADDR=0x0000_2000. Each region is 4 KB, decoded on mr_addra[31:12]; word index = mr_addra[11:2].
REQ-004 Write occurs on a posedge of aclk when mr_ena=1 and mr_wea!=0. Each byte lane is written where its mr_wea bit is 1.
REQ-005 Read path is combinational: mr_douta = selected word whenever mr_ena=1 and mr_wea=0; otherwise 0. Unmapped addresses read 0, and writes to them are ignored.
REQ-006 REGS region: 64 x 32-bit registers (word index 0..63), read/write. Higher indices alias modulo 64.
REQ-007 CEL_VARS region: 64 x 32-bit read/write storage with the same indexing rule.
REQ-008 UTIL region (fill engine):
- 0x0 DST: destination byte address.
- 0x4 CTRL/STAT: writing bit0=1 starts a fill; read bit0=done, bit1=busy.
- 0x8 LEN: word count.
- 0xC PAT: 32-bit fill pattern.
REQ-009 Fill FSM states are IDLE, ADDR, RESP, DONE:
- Start clears done, latches DST/LEN/PAT, loads cnt=0, and enters ADDR (or DONE if LEN=0).
- ADDR: asserts aw_valid and w_valid together, with aw_addr=DST+4*cnt, w_data=PAT, w_strb all ones, prot=0. Each valid drops independently once its ready is seen; when both have handshaked, go to RESP.
- RESP: b_ready=1; on b_valid, cnt+1. If cnt+1==LEN go to DONE, else go to ADDR.
- DONE: sets done=1 and returns to IDLE.
REQ-010 A start written while busy is ignored. A DST/LEN/PAT write while busy updates the registers but not the active fill. Address increments wrap modulo 2^AXI_ADDR_WIDTH. b_resp is ignored.
REQ-011 Read channel is unused: ar_valid=0, ar_addr=0, ar_prot=0, r_ready=1.

Reset
REQ-012 On reset (!aresetn or mr_rsta at posedge):
- All storage is cleared to 0.
- FSM goes to IDLE, with done=0 and busy=0.
- All AXI valids are 0; b_ready=0; mr_douta follows REQ-005.
REQ-013 Reset asserted mid-fill aborts the fill immediately, with no further AXI handshakes.

Configuration
REQ-014 Macro MCORE_DEBUG_EN:
- Defined: debug = {cnt[15:0], 12'b0, state[1:0], busy, done}.
- Undefined: debug = 0.

Structure
REQ-015 Package mcore_defs holds the region base constants (M_REGS_ADDR, M_CEL_VARS_ADDR, M_UTIL_ADDR), the UTIL register offsets and the fill FSM state enum.
REQ-016 The fill engine is the sub-module mcore_util_fill; address decode and storage sit in mcore_top.

Verification
REQ-017 Write 0x12345678 to CEL_VARS+0x0, then read it -> 0x12345678. Repeat with +0x40/0xcafecafe, +0x80/0xdeaddead and +0xC0/0xbeefbeef.
REQ-018 Fill test:
- Stimulus: DST=0x7000_0000, LEN=8, PAT=0xcafe_0000, CTRL=1, with all readies=1 and b_valid=1.
- Response: exactly 8 w beats of 0xcafe0000 at addresses 0x7000_0000..0x7000_001C, then STAT bit0=1.
REQ-019 Second fill with PAT=0xbeef_0000 and CTRL=1: STAT bit0 reads 0 in the cycle after start, then 8 beats of 0xbeef0000, then done.
REQ-020 Hold aw_ready=0 for 3 cycles with w_ready=1 -> w_valid drops after 1 cycle, aw_valid holds, and no duplicate beat occurs.
REQ-021 Assert aresetn=0 mid-fill -> valids go to 0 next cycle, STAT reads 0, and REGS/CEL_VARS read 0.
REQ-022 Byte-enable test: write 0xFFFFFFFF to REGS+0x10, then 0x00000000 with mr_wea=0b0001 -> read 0xFFFFFF00.
